pipeline_ctrl: RTL and testbench

Central interlock and sequencing controller for the 5-stage pipeline (IF, ID, EX, MA, WB).
- Consumes the ID-stage register-use flags (NEED_RS1/NEED_RS2), the EX and MA destination and write-enable fields, the EX branch/jump resolution and the memory busy line.
- Produces the pipeline-register write enables, flushes and operand-forwarding selects.
- Owns the HLT sequence: drains in-flight instructions, then freezes the core.

---
 rtl/pipeline_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline interlock, forwarding and HLT sequencing controller
module pipeline_ctrl #(
  parameter int REG_AW       = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_need_rs1,
  input  logic              id_need_rs2,
  input  logic              id_halt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_we,
  input  logic              ex_is_load,
  input  logic              ex_take,
  input  logic [REG_AW-1:0] ma_rd,
  input  logic              ma_reg_we,
  input  logic              mem_busy,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              if_id_flush,
  output logic              id_ex_we,
  output logic              id_ex_flush,
  output logic              ex_ma_we,
  output logic              ma_wb_we,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic ex_hit_a, ex_hit_b, ma_hit_a, ma_hit_b, lu;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // A load result is not available in EX, so it never forwards from there.
  assign ex_hit_a = id_need_rs1 && ex_reg_we && (ex_rd == id_rs1);
  assign ex_hit_b = id_need_rs2 && ex_reg_we && (ex_rd == id_rs2);
  assign ma_hit_a = id_need_rs1 && ma_reg_we && (ma_rd == id_rs1);
  assign ma_hit_b = id_need_rs2 && ma_reg_we && (ma_rd == id_rs2);
  assign lu       = (ex_hit_a || ex_hit_b) && ex_is_load;

  assign fwd_a_raw = (ex_hit_a && !ex_is_load) ? 2'b01 : (ma_hit_a ? 2'b10 : 2'b00);
  assign fwd_b_raw = (ex_hit_b && !ex_is_load) ? 2'b01 : (ma_hit_b ? 2'b10 : 2'b00);

  assign stall_cnt = stall_q;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    stall_d     = stall_q;
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_we    = 1'b1;
    id_ex_flush = 1'b0;
    ex_ma_we    = 1'b1;
    ma_wb_we    = 1'b1;
    fwd_a       = fwd_a_raw;
    fwd_b       = fwd_b_raw;
    halted      = 1'b0;

    if (rst) begin
      state_d     = S_RUN;
      drain_d     = '0;
      stall_d     = '0;
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_we    = 1'b0;
      ex_ma_we    = 1'b0;
      ma_wb_we    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
    end else if (state_q == S_HALTED) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      id_ex_we = 1'b0;
      ex_ma_we = 1'b0;
      ma_wb_we = 1'b0;
      halted   = 1'b1;
    end else if (mem_busy) begin
      // Whole pipe freezes; a pending redirect is serviced when memory frees up.
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      id_ex_we = 1'b0;
      ex_ma_we = 1'b0;
      ma_wb_we = 1'b0;
    end else if (state_q == S_DRAIN) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
      drain_d     = drain_q - DRAIN_W'(1);
      if (drain_q <= DRAIN_W'(1)) begin
        state_d = S_HALTED;
      end
    end else if (ex_take) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (id_halt) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = S_DRAIN;
      drain_d     = DRAIN_W'(DRAIN_CYCLES);
    end else if (lu) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
      if (stall_q != {CNT_W{1'b1}}) begin
        stall_d = stall_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    drain_q <= drain_d;
    stall_q <= stall_d;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam logic [4:0] WE_ALL   = 5'b11111;
  localparam logic [4:0] WE_NONE  = 5'b00000;
  localparam logic [4:0] WE_STALL = 5'b00111;
  localparam logic [1:0] FL_NONE  = 2'b00;
  localparam logic [1:0] FL_BOTH  = 2'b11;
  localparam logic [1:0] FL_IDEX  = 2'b01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, ma_rd;
  logic       id_need_rs1, id_need_rs2, id_halt;
  logic       ex_reg_we, ex_is_load, ex_take, ma_reg_we, mem_busy;

  logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_ma_we, ma_wb_we;
  logic [1:0]  fwd_a, fwd_b;
  logic        halted;
  logic [15:0] stall_cnt;

  logic        s_pc_we, s_if_id_we, s_if_id_flush, s_id_ex_we, s_id_ex_flush, s_ex_ma_we, s_ma_wb_we;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic        s_halted;
  logic [1:0]  s_stall_cnt;

  pipeline_ctrl #(.REG_AW(5), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_need_rs1(id_need_rs1), .id_need_rs2(id_need_rs2),
    .id_halt(id_halt), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
    .ex_take(ex_take), .ma_rd(ma_rd), .ma_reg_we(ma_reg_we), .mem_busy(mem_busy),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush), .id_ex_we(id_ex_we),
    .id_ex_flush(id_ex_flush), .ex_ma_we(ex_ma_we), .ma_wb_we(ma_wb_we),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.REG_AW(5), .DRAIN_CYCLES(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_need_rs1(id_need_rs1), .id_need_rs2(id_need_rs2),
    .id_halt(id_halt), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
    .ex_take(ex_take), .ma_rd(ma_rd), .ma_reg_we(ma_reg_we), .mem_busy(mem_busy),
    .pc_we(s_pc_we), .if_id_we(s_if_id_we), .if_id_flush(s_if_id_flush), .id_ex_we(s_id_ex_we),
    .id_ex_flush(s_id_ex_flush), .ex_ma_we(s_ex_ma_we), .ma_wb_we(s_ma_wb_we),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .halted(s_halted), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    string       tag;
    logic [4:0]  we;
    logic [1:0]  fl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        halted;
    logic [15:0] cnt;
    logic [1:0]  sat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_cnt;
  logic [1:0]  m_sat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : chk
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({e.tag, "/we"}, 32'({pc_we, if_id_we, id_ex_we, ex_ma_we, ma_wb_we}), 32'(e.we));
      check_eq({e.tag, "/flush"}, 32'({if_id_flush, id_ex_flush}), 32'(e.fl));
      check_eq({e.tag, "/fwd_a"}, 32'(fwd_a), 32'(e.fa));
      check_eq({e.tag, "/fwd_b"}, 32'(fwd_b), 32'(e.fb));
      check_eq({e.tag, "/halted"}, 32'(halted), 32'(e.halted));
      check_eq({e.tag, "/stall_cnt"}, 32'(stall_cnt), 32'(e.cnt));
      check_eq({e.tag, "/sat_cnt"}, 32'(s_stall_cnt), 32'(e.sat));
    end
  end

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; ma_rd = '0;
    id_need_rs1 = 0; id_need_rs2 = 0; id_halt = 0;
    ex_reg_we = 0; ex_is_load = 0; ex_take = 0; ma_reg_we = 0; mem_busy = 0;
  endtask

  // Push this cycle's expectation, then advance the model counters across the edge.
  task automatic step(input string tag, input logic [4:0] we, input logic [1:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic hlt,
                      input logic inc);
    exp_t e;
    e.tag = tag; e.we = we; e.fl = fl; e.fa = fa; e.fb = fb;
    e.halted = hlt; e.cnt = m_cnt; e.sat = m_sat;
    sb.push_back(e);
    if (rst) begin
      m_cnt = '0;
      m_sat = '0;
    end else if (inc) begin
      if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
      if (m_sat != 2'b11) m_sat = m_sat + 2'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    m_cnt = '0;
    m_sat = '0;

    id_rs1 = 3; id_need_rs1 = 1; ex_rd = 3; ex_reg_we = 1; ex_take = 1; id_halt = 1;
    step("rst_force", WE_NONE, FL_BOTH, 2'b00, 2'b00, 0, 0);
    rst = 0;

    idle();
    id_rs1 = 3; id_need_rs1 = 1; ex_rd = 3; ex_reg_we = 1; ma_rd = 3; ma_reg_we = 1;
    step("fwd_ex", WE_ALL, FL_NONE, 2'b01, 2'b00, 0, 0);
    ex_reg_we = 0;
    step("fwd_ma", WE_ALL, FL_NONE, 2'b10, 2'b00, 0, 0);
    id_need_rs1 = 0;
    step("fwd_none", WE_ALL, FL_NONE, 2'b00, 2'b00, 0, 0);

    idle();
    id_rs2 = 9; id_need_rs2 = 1; ex_rd = 9; ex_reg_we = 1; ma_rd = 9; ma_reg_we = 1;
    step("fwdb_ex", WE_ALL, FL_NONE, 2'b00, 2'b01, 0, 0);
    idle();
    id_rs1 = 0; id_need_rs1 = 1; ma_rd = 0; ma_reg_we = 1;
    id_rs2 = 31; id_need_rs2 = 1; ex_rd = 31; ex_reg_we = 1;
    step("fwd_r0_r31", WE_ALL, FL_NONE, 2'b10, 2'b01, 0, 0);

    idle();
    ex_is_load = 1; ex_rd = 5; ex_reg_we = 1; id_rs2 = 5; id_need_rs2 = 1;
    step("lu", WE_STALL, FL_IDEX, 2'b00, 2'b00, 0, 1);
    id_need_rs2 = 0;
    step("lu_off", WE_ALL, FL_NONE, 2'b00, 2'b00, 0, 0);

    id_need_rs2 = 1; ex_take = 1; id_halt = 1;
    step("take_wins", WE_ALL, FL_BOTH, 2'b00, 2'b00, 0, 0);
    idle();
    repeat (2) step("after_take", WE_ALL, FL_NONE, 2'b00, 2'b00, 0, 0);

    ex_take = 1; mem_busy = 1;
    repeat (3) step("busy", WE_NONE, FL_NONE, 2'b00, 2'b00, 0, 0);
    mem_busy = 0;
    step("busy_release", WE_ALL, FL_BOTH, 2'b00, 2'b00, 0, 0);
    ex_take = 0;
    step("post_release", WE_ALL, FL_NONE, 2'b00, 2'b00, 0, 0);

    id_halt = 1;
    step("halt_enter", WE_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0);
    id_halt = 0; ex_take = 1;
    step("drain_take", WE_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0);
    ex_take = 0;
    repeat (2) step("drain", WE_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0);
    step("halted", WE_NONE, FL_NONE, 2'b00, 2'b00, 1, 0);
    ex_take = 1; id_halt = 1; ex_is_load = 1; ex_rd = 5; ex_reg_we = 1; id_rs2 = 5; id_need_rs2 = 1;
    step("halted_hold", WE_NONE, FL_NONE, 2'b00, 2'b00, 1, 0);
    idle();
    rst = 1;
    step("rst_from_halt", WE_NONE, FL_BOTH, 2'b00, 2'b00, 0, 0);
    rst = 0;

    id_halt = 1;
    step("halt_enter2", WE_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0);
    id_halt = 0;
    step("drain2_a", WE_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0);
    mem_busy = 1;
    step("drain2_busy", WE_NONE, FL_NONE, 2'b00, 2'b00, 0, 0);
    mem_busy = 0;
    repeat (2) step("drain2_b", WE_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0);
    step("halted2", WE_NONE, FL_NONE, 2'b00, 2'b00, 1, 0);

    rst = 1;
    step("rst2", WE_NONE, FL_BOTH, 2'b00, 2'b00, 0, 0);
    rst = 0;
    ex_is_load = 1; ex_rd = 7; ex_reg_we = 1; id_rs1 = 7; id_need_rs1 = 1;
    repeat (5) step("lu_sat", WE_STALL, FL_IDEX, 2'b00, 2'b00, 0, 1);
    idle();
    id_halt = 1;
    step("halt_enter3", WE_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0);
    id_halt = 0;
    step("drain3", WE_STALL, FL_IDEX, 2'b00, 2'b00, 0, 0);
    rst = 1;
    step("rst_mid_drain", WE_NONE, FL_BOTH, 2'b00, 2'b00, 0, 0);
    rst = 0;
    repeat (5) step("after_rst", WE_ALL, FL_NONE, 2'b00, 2'b00, 0, 0);

    repeat (4) begin
      if (sb.size() > 0) @(negedge clk);
    end
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
